// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the sprite (OAM) DMA engine.
// State encodings, bus direction values and default register addresses.
package oam_dma_pkg;

    localparam logic [15:0] DEFAULT_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] DEFAULT_OAM_DATA_ADDR = 16'h2004;

    // Same read/write encoding as the CPU bus.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        DMA_IDLE  = 3'd0,
        DMA_HALT  = 3'd1,
        DMA_ALIGN = 3'd2,
        DMA_READ  = 3'd3,
        DMA_WRITE = 3'd4
    } dma_state_t;

    function automatic logic is_trigger(input logic [15:0] a, input logic rw,
                                        input logic [15:0] reg_addr);
        return (a == reg_addr) && (rw == RW_WRITE);
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side bus and DMA-side bus signals of the OAM DMA engine.
// The slave modport is the DMA engine; master is the system/bench side.
interface oam_dma_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_rw;
    logic [7:0]  mem_d;
    logic        dma_active;
    logic [15:0] dma_a;
    logic [7:0]  dma_d;
    logic        dma_rw;
    logic        dma_done;

    modport master (
        output cpu_a, cpu_d, cpu_rw, mem_d,
        input  dma_active, dma_a, dma_d, dma_rw, dma_done
    );

    modport slave (
        input  cpu_a, cpu_d, cpu_rw, mem_d,
        output dma_active, dma_a, dma_d, dma_rw, dma_done
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: a CPU write to the page register halts the CPU and copies
// 256 bytes from page P into the OAM data port, one read + one write per byte.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DEFAULT_DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DEFAULT_OAM_DATA_ADDR
) (
    input logic       clk,
    input logic       rst,
    oam_dma_if.slave  bus
);

    dma_state_t  state;
    logic        odd;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic        active_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic        rw_q;
    logic        done_q;

    // Outputs are loaded with the values of the state being entered, so every
    // output is a flop. data_q doubles as the read-data buffer: it captures
    // mem_d at the end of READ and is presented unchanged during WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DMA_IDLE;
            odd      <= 1'b0;
            page     <= 8'h00;
            idx      <= 8'h00;
            active_q <= 1'b0;
            addr_q   <= 16'h0000;
            data_q   <= 8'h00;
            rw_q     <= RW_READ;
            done_q   <= 1'b0;
        end else begin
            odd    <= ~odd;
            done_q <= 1'b0;
            case (state)
                DMA_IDLE: begin
                    if (is_trigger(bus.cpu_a, bus.cpu_rw, DMA_REG_ADDR)) begin
                        page     <= bus.cpu_d;
                        idx      <= 8'h00;
                        state    <= DMA_HALT;
                        active_q <= 1'b1;
                    end
                end
                DMA_HALT: begin
                    if (odd) begin
                        state <= DMA_ALIGN;
                    end else begin
                        state  <= DMA_READ;
                        addr_q <= {page, idx};
                        rw_q   <= RW_READ;
                    end
                end
                DMA_ALIGN: begin
                    state  <= DMA_READ;
                    addr_q <= {page, idx};
                    rw_q   <= RW_READ;
                end
                DMA_READ: begin
                    state  <= DMA_WRITE;
                    data_q <= bus.mem_d;
                    addr_q <= OAM_DATA_ADDR;
                    rw_q   <= RW_WRITE;
                end
                DMA_WRITE: begin
                    if (idx == 8'hFF) begin
                        state    <= DMA_IDLE;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                        addr_q   <= 16'h0000;
                        data_q   <= 8'h00;
                        rw_q     <= RW_READ;
                    end else begin
                        idx    <= idx + 8'd1;
                        state  <= DMA_READ;
                        addr_q <= {page, idx + 8'd1};
                        rw_q   <= RW_READ;
                    end
                end
                default: begin
                    state    <= DMA_IDLE;
                    active_q <= 1'b0;
                    addr_q   <= 16'h0000;
                    data_q   <= 8'h00;
                    rw_q     <= RW_READ;
                end
            endcase
        end
    end

    assign bus.dma_active = active_q;
    assign bus.dma_a      = addr_q;
    assign bus.dma_d      = data_q;
    assign bus.dma_rw     = rw_q;
    assign bus.dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus pushes the expected per-cycle bus
// trace of each transfer; a negedge monitor pops and compares it.
module tb_oam_dma;
    import oam_dma_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic par;

    oam_dma_if bus();

    oam_dma dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        active;
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        logic        chk_d;
        logic        done;
    } ev_t;

    ev_t exp_q[$];
    ev_t cur;
    int  checks = 0;
    int  errors = 0;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA6;
    endfunction

    assign bus.mem_d = bus.dma_rw ? mem_byte(bus.dma_a) : 8'h00;

    // Reference cycle parity: 0 in the first cycle after reset, toggling after.
    always @(posedge clk) par <= rst ? 1'b0 : ~par;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.dma_active === 1'b1 || bus.dma_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_activity",
                             {5'd0, bus.dma_active, bus.dma_a, bus.dma_rw, bus.dma_d, bus.dma_done},
                             32'd0);
            end else begin
                cur = exp_q.pop_front();
                check_output("bus_trace",
                             {5'd0, bus.dma_active, bus.dma_a, bus.dma_rw,
                              cur.chk_d ? bus.dma_d : 8'h00, bus.dma_done},
                             {5'd0, cur.active, cur.a, cur.rw,
                              cur.chk_d ? cur.d : 8'h00, cur.done});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] d, input logic rw);
        bus.cpu_a  = a;
        bus.cpu_d  = d;
        bus.cpu_rw = rw;
    endtask

    task automatic push_ev(input logic act, input logic [15:0] a, input logic rw,
                           input logic [7:0] d, input logic chk, input logic done);
        ev_t e;
        e.active = act; e.a = a; e.rw = rw; e.d = d; e.chk_d = chk; e.done = done;
        exp_q.push_back(e);
    endtask

    // want_align: 0 = no extra cycle, 1 = extra cycle, anything else = whatever parity comes.
    task automatic trigger(input logic [7:0] page, input int want_align);
        logic [15:0] src;
        if ((want_align == 0 && par == 1'b0) || (want_align == 1 && par == 1'b1))
            step();
        apply_stimulus(16'h4014, page, RW_WRITE);
        step();
        apply_stimulus(16'h0000, 8'h00, RW_READ);
        push_ev(1'b1, 16'h0000, RW_READ, 8'h00, 1'b1, 1'b0);
        if (par) push_ev(1'b1, 16'h0000, RW_READ, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 256; i++) begin
            src = {page, 8'(i)};
            push_ev(1'b1, src, RW_READ, 8'h00, 1'b0, 1'b0);
            push_ev(1'b1, 16'h2004, RW_WRITE, mem_byte(src), 1'b1, 1'b0);
        end
        push_ev(1'b0, 16'h0000, RW_READ, 8'h00, 1'b1, 1'b1);
    endtask

    // CPU traffic (including page-register writes) is thrown at the busy DMA
    // but stopped a few cycles before the end so nothing lands in IDLE.
    task automatic wait_drain(input logic noisy);
        int r;
        for (int k = 0; k < 700 && exp_q.size() != 0; k++) begin
            if (noisy && exp_q.size() > 4) begin
                r = $urandom_range(0, 3);
                case (r)
                    0: apply_stimulus(16'h4014, 8'h07, RW_WRITE);
                    1: apply_stimulus(16'h4014, 8'($urandom), 1'($urandom));
                    2: apply_stimulus(16'h2004, 8'($urandom), RW_WRITE);
                    default: apply_stimulus(16'($urandom), 8'($urandom), 1'($urandom));
                endcase
            end else begin
                apply_stimulus(16'h0000, 8'h00, RW_READ);
            end
            step();
        end
        apply_stimulus(16'h0000, 8'h00, RW_READ);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
    endtask

    task automatic check_idle_values(input string name);
        @(negedge clk);
        check_output(name, {5'd0, bus.dma_active, bus.dma_a, bus.dma_rw, bus.dma_d, bus.dma_done},
                     {5'd0, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(16'h0000, 8'h00, RW_READ);
        step();
        step();
        rst = 1'b0;
        check_idle_values("reset_state");
        repeat (4) step();

        apply_stimulus(16'h4014, 8'h02, RW_READ);
        step();
        apply_stimulus(16'h4015, 8'h02, RW_WRITE);
        step();
        apply_stimulus(16'h0000, 8'h00, RW_READ);
        check_idle_values("no_trigger_access");
        step();

        trigger(8'h02, 1);
        wait_drain(1'b1);
        trigger(8'h02, 0);
        wait_drain(1'b1);
        trigger(8'h03, 2);
        wait_drain(1'b0);
        trigger(8'($urandom), 2);
        wait_drain(1'b1);

        // Abandon a transfer part-way through with reset.
        trigger(8'h05, 2);
        repeat (201) step();
        rst = 1'b1;
        step();
        exp_q.delete();
        rst = 1'b0;
        check_idle_values("reset_mid_transfer");
        repeat (5) step();
        check_idle_values("no_done_after_reset");
        trigger(8'h06, 2);
        wait_drain(1'b0);

        trigger(8'hFF, 2);
        wait_drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
